// File: rtl/vc_arbiter.sv
// vc_arbiter: two-VC to two-destination arbiter with VC0 priority and VC1
// starvation relief. Pops are combinational in the grant cycle; the granted
// word and its destination push are registered one cycle later.
module vc_arbiter #(
  parameter int unsigned DATA_W       = 6,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              active_in,
  input  logic [DATA_W-1:0] vc0_data,
  input  logic              vc0_empty,
  input  logic [DATA_W-1:0] vc1_data,
  input  logic              vc1_empty,
  input  logic              d0_almost_full,
  input  logic              d1_almost_full,
  output logic              vc0_pop,
  output logic              vc1_pop,
  output logic              d0_push,
  output logic              d1_push,
  output logic [DATA_W-1:0] data_out,
  output logic              last_grant,
  output logic              arb_idle
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]  r_starve_cnt;
  logic              r_d0_push;
  logic              r_d1_push;
  logic [DATA_W-1:0] r_data_out;
  logic              r_last_grant;
  logic              r_arb_idle;

  logic              w_vc0_elig;
  logic              w_vc1_elig;
  logic              w_grant0;
  logic              w_grant1;
  logic              w_starved;
  logic              w_dest_d1;
  logic [DATA_W-1:0] w_grant_data;

  // Eligibility and grant decision for the current cycle; reset gates all pops.
  always_comb begin
    w_vc0_elig   = 1'b0;
    w_vc1_elig   = 1'b0;
    w_grant0     = 1'b0;
    w_grant1     = 1'b0;
    w_starved    = 1'b0;
    w_dest_d1    = 1'b0;
    w_grant_data = '0;

    w_vc0_elig = active_in && !vc0_empty &&
                 !(vc0_data[DATA_W-1] ? d1_almost_full : d0_almost_full);
    w_vc1_elig = active_in && !vc1_empty &&
                 !(vc1_data[DATA_W-1] ? d1_almost_full : d0_almost_full);
    w_starved  = (r_starve_cnt == LIMIT);

    if (reset) begin
      w_grant0 = w_vc0_elig && (!w_vc1_elig || !w_starved);
      w_grant1 = w_vc1_elig && (!w_vc0_elig || w_starved);
    end

    if (w_grant1) begin
      w_grant_data = vc1_data;
    end else begin
      w_grant_data = vc0_data;
    end
    w_dest_d1 = w_grant_data[DATA_W-1];
  end

  assign vc0_pop    = w_grant0;
  assign vc1_pop    = w_grant1;
  assign d0_push    = r_d0_push;
  assign d1_push    = r_d1_push;
  assign data_out   = r_data_out;
  assign last_grant = r_last_grant;
  assign arb_idle   = r_arb_idle;

  // Register the granted word, its destination push, and the starvation count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_starve_cnt <= '0;
      r_d0_push    <= 1'b0;
      r_d1_push    <= 1'b0;
      r_data_out   <= '0;
      r_last_grant <= 1'b0;
      r_arb_idle   <= 1'b1;
    end else begin
      r_d0_push  <= (w_grant0 || w_grant1) && !w_dest_d1;
      r_d1_push  <= (w_grant0 || w_grant1) && w_dest_d1;
      r_arb_idle <= !(w_grant0 || w_grant1);
      if (w_grant0 || w_grant1) begin
        r_data_out   <= w_grant_data;
        r_last_grant <= w_grant1;
      end
      if (w_grant1) begin
        r_starve_cnt <= '0;
      end else if (w_grant0 && w_vc1_elig && !w_starved) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vc_arbiter.sv
// tb_vc_arbiter: directed literal checks plus randomized stimulus checked
// every cycle against a behavioural model of the arbitration rules.
module tb_vc_arbiter;

  localparam int DW    = 6;
  localparam int LIMIT = 4;

  logic          clk;
  logic          reset;
  logic          active_in;
  logic [DW-1:0] vc0_data;
  logic          vc0_empty;
  logic [DW-1:0] vc1_data;
  logic          vc1_empty;
  logic          d0_almost_full;
  logic          d1_almost_full;
  logic          vc0_pop;
  logic          vc1_pop;
  logic          d0_push;
  logic          d1_push;
  logic [DW-1:0] data_out;
  logic          last_grant;
  logic          arb_idle;

  int n_chk = 0;
  int n_err = 0;

  vc_arbiter #(.DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk            (clk),
    .reset          (reset),
    .active_in      (active_in),
    .vc0_data       (vc0_data),
    .vc0_empty      (vc0_empty),
    .vc1_data       (vc1_data),
    .vc1_empty      (vc1_empty),
    .d0_almost_full (d0_almost_full),
    .d1_almost_full (d1_almost_full),
    .vc0_pop        (vc0_pop),
    .vc1_pop        (vc1_pop),
    .d0_push        (d0_push),
    .d1_push        (d1_push),
    .data_out       (data_out),
    .last_grant     (last_grant),
    .arb_idle       (arb_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state: expected registered outputs and VC0-streak count.
  logic          exp_d0   = 1'b0;
  logic          exp_d1   = 1'b0;
  logic [DW-1:0] exp_data = '0;
  logic          exp_last = 1'b0;
  logic          exp_idle = 1'b1;
  int            m_streak = 0;

  // Compare process: outputs are stable at the falling edge; then advance model.
  always @(negedge clk) begin
    bit e0, e1;
    int g;
    logic [DW-1:0] w;
    chk("m_d0_push",    32'(d0_push),    32'(exp_d0));
    chk("m_d1_push",    32'(d1_push),    32'(exp_d1));
    chk("m_data_out",   32'(data_out),   32'(exp_data));
    chk("m_last_grant", 32'(last_grant), 32'(exp_last));
    chk("m_arb_idle",   32'(arb_idle),   32'(exp_idle));

    e0 = active_in && !vc0_empty && !(vc0_data[DW-1] ? d1_almost_full : d0_almost_full);
    e1 = active_in && !vc1_empty && !(vc1_data[DW-1] ? d1_almost_full : d0_almost_full);
    if (!reset)        g = -1;
    else if (e0 && e1) g = (m_streak == LIMIT) ? 1 : 0;
    else if (e0)       g = 0;
    else if (e1)       g = 1;
    else               g = -1;

    chk("m_vc0_pop", 32'(vc0_pop), 32'(g == 0));
    chk("m_vc1_pop", 32'(vc1_pop), 32'(g == 1));

    if (!reset) begin
      exp_d0 = 0; exp_d1 = 0; exp_data = '0; exp_last = 0; exp_idle = 1; m_streak = 0;
    end else if (g < 0) begin
      exp_d0 = 0; exp_d1 = 0; exp_idle = 1;
    end else begin
      w = (g == 1) ? vc1_data : vc0_data;
      exp_data = w;
      exp_d0   = !w[DW-1];
      exp_d1   = w[DW-1];
      exp_last = (g == 1);
      exp_idle = 0;
      if (g == 1)                         m_streak = 0;
      else if (e1 && m_streak < LIMIT)    m_streak = m_streak + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; active_in = 1'b1;
    vc0_data = 6'b000111; vc0_empty = 1'b0;
    vc1_data = 6'b101010; vc1_empty = 1'b0;
    d0_almost_full = 1'b0; d1_almost_full = 1'b0;

    // Reset held two cycles with both VCs ready: no pops, reset values.
    tick(); #2;
    chk("rst_vc0_pop", 32'(vc0_pop), 32'd0);
    chk("rst_vc1_pop", 32'(vc1_pop), 32'd0);
    tick();
    chk("rst_d0_push",  32'(d0_push),  32'd0);
    chk("rst_d1_push",  32'(d1_push),  32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_idle",     32'(arb_idle), 32'd1);
    chk("rst_last",     32'(last_grant), 32'd0);

    // Single VC0 word to D0.
    reset = 1'b1; vc0_data = 6'b010101; vc1_empty = 1'b1;
    #2;
    chk("one_vc0_pop", 32'(vc0_pop), 32'd1);
    chk("one_vc1_pop", 32'(vc1_pop), 32'd0);
    tick();
    chk("one_d0_push",  32'(d0_push),  32'd1);
    chk("one_d1_push",  32'(d1_push),  32'd0);
    chk("one_data_out", 32'(data_out), 32'b010101);
    chk("one_idle",     32'(arb_idle), 32'd0);

    // Starvation pattern from a fresh count: VC0 x4 then VC1, repeating.
    reset = 1'b0;
    tick();
    reset = 1'b1; vc0_data = 6'b000001; vc1_data = 6'b100010; vc1_empty = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #2;
      chk("starve_vc1_pop", 32'(vc1_pop), 32'(i % 5 == 4));
      chk("starve_vc0_pop", 32'(vc0_pop), 32'(i % 5 != 4));
      tick();
    end

    // VC0 blocked by D1 almost-full must not block VC1 to D0.
    vc0_data = 6'b100001; vc1_data = 6'b000011; d1_almost_full = 1'b1;
    #2;
    chk("hol_vc0_pop", 32'(vc0_pop), 32'd0);
    chk("hol_vc1_pop", 32'(vc1_pop), 32'd1);
    tick();
    chk("hol_d0_push",  32'(d0_push),  32'd1);
    chk("hol_data_out", 32'(data_out), 32'b000011);
    chk("hol_last",     32'(last_grant), 32'd1);

    // active_in drops after a grant: push completes, then idle with no pops.
    vc0_data = 6'b000101; vc1_empty = 1'b1; d1_almost_full = 1'b0;
    #2;
    chk("act_vc0_pop", 32'(vc0_pop), 32'd1);
    tick();
    active_in = 1'b0;
    chk("act_d0_push", 32'(d0_push), 32'd1);
    chk("act_data",    32'(data_out), 32'b000101);
    #2;
    chk("act_no_pop", 32'(vc0_pop | vc1_pop), 32'd0);
    tick();
    chk("act_idle",    32'(arb_idle), 32'd1);
    chk("act_no_push", 32'(d0_push), 32'd0);
    chk("act_hold",    32'(data_out), 32'b000101);
    active_in = 1'b1;

    // D0 almost-full rising at the push edge: push completes, D0 then stalls.
    vc0_data = 6'b001001;
    #2;
    chk("af_vc0_pop", 32'(vc0_pop), 32'd1);
    tick();
    d0_almost_full = 1'b1;
    chk("af_d0_push", 32'(d0_push), 32'd1);
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("af_stall_pop", 32'(vc0_pop), 32'd0);
      tick();
      chk("af_stall_push", 32'(d0_push), 32'd0);
    end
    d0_almost_full = 1'b0;
    #2;
    chk("af_resume_pop", 32'(vc0_pop), 32'd1);
    tick();

    // Randomized traffic; the compare process checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      reset          = ($urandom_range(0, 63) != 0);
      active_in      = ($urandom_range(0, 9) != 0);
      vc0_empty      = ($urandom_range(0, 3) == 0);
      vc1_empty      = ($urandom_range(0, 3) == 0);
      vc0_data       = DW'($urandom);
      vc1_data       = DW'($urandom);
      d0_almost_full = ($urandom_range(0, 3) == 0);
      d1_almost_full = ($urandom_range(0, 3) == 0);
      tick();
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
